// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - VGA pixel fetch: framebuffer read, test patterns, fixed-latency sync alignment
module vga_pixel_fetch #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        DE,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic [1:0]  mode,
  output logic [16:0] fb_addr,
  output logic        fb_re,
  input  logic [15:0] fb_rdata,
  output logic        vga_h_sync,
  output logic        vga_v_sync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic [7:0]  frame_cnt
);

  localparam logic [1:0] MODE_FB    = 2'b00;
  localparam logic [1:0] MODE_BARS  = 2'b01;
  localparam logic [1:0] MODE_CHECK = 2'b10;
  localparam logic [1:0] MODE_BLACK = 2'b11;

  localparam logic [11:0] COL_WHITE   = 12'hFFF;
  localparam logic [11:0] COL_YELLOW  = 12'hFF0;
  localparam logic [11:0] COL_CYAN    = 12'h0FF;
  localparam logic [11:0] COL_GREEN   = 12'h0F0;
  localparam logic [11:0] COL_MAGENTA = 12'hF0F;
  localparam logic [11:0] COL_RED     = 12'hF00;
  localparam logic [11:0] COL_BLUE    = 12'h00F;
  localparam logic [11:0] COL_BLACK   = 12'h000;

  // Source select latched once per frame so a mid-frame change never tears the image
  logic [1:0]  mode_q;
  logic        frame_start;
  logic [1:0]  mode_cur;

  // Framebuffer address generation (2x upscale of a 320x240 buffer)
  logic [16:0] y_half;
  logic [16:0] x_half;
  logic [16:0] addr_next;

  // Pattern generation at stage 0
  logic [11:0] bar_col;
  logic [11:0] checker_col;
  logic [11:0] pattern_col;
  logic        fb_sel;

  // Delay line matching the framebuffer read latency; index 0 is stage 0
  logic        de_pipe  [0:RD_LAT];
  logic        hs_pipe  [0:RD_LAT];
  logic        vs_pipe  [0:RD_LAT];
  logic        sel_pipe [0:RD_LAT];
  logic [11:0] col_pipe [0:RD_LAT];

  // Bits of the RGB565 word dropped when truncating to RGB444
  logic        unused_rdata_bits;

  assign frame_start = (x_pixel == 10'd0) && (y_pixel == 10'd0);

  // The first pixel of a frame already uses the newly selected source
  assign mode_cur = frame_start ? mode : mode_q;

  assign y_half    = {8'd0, y_pixel[9:1]};
  assign x_half    = {8'd0, x_pixel[9:1]};
  // y_half*320 built from two shifts to avoid a multiplier
  assign addr_next = (y_half << 8) + (y_half << 6) + x_half;

  assign unused_rdata_bits = &{1'b0, fb_rdata[11], fb_rdata[6], fb_rdata[5], fb_rdata[0]};

  // Eight 80-pixel colour bars across the visible width; anything beyond is black
  always_comb begin
    bar_col = COL_BLACK;
    if (x_pixel < 10'd80) begin
      bar_col = COL_WHITE;
    end else if (x_pixel < 10'd160) begin
      bar_col = COL_YELLOW;
    end else if (x_pixel < 10'd240) begin
      bar_col = COL_CYAN;
    end else if (x_pixel < 10'd320) begin
      bar_col = COL_GREEN;
    end else if (x_pixel < 10'd400) begin
      bar_col = COL_MAGENTA;
    end else if (x_pixel < 10'd480) begin
      bar_col = COL_RED;
    end else if (x_pixel < 10'd560) begin
      bar_col = COL_BLUE;
    end else begin
      bar_col = COL_BLACK;
    end
  end

  assign checker_col = (x_pixel[5] ^ y_pixel[5]) ? COL_WHITE : COL_BLACK;

  // Select the pattern colour for this pixel; framebuffer pixels are resolved at the output stage
  always_comb begin
    pattern_col = COL_BLACK;
    fb_sel      = 1'b0;
    case (mode_cur)
      MODE_FB:    fb_sel      = 1'b1;
      MODE_BARS:  pattern_col = bar_col;
      MODE_CHECK: pattern_col = checker_col;
      MODE_BLACK: pattern_col = COL_BLACK;
      default:    pattern_col = COL_BLACK;
    endcase
  end

  // Frame start bookkeeping: latch source select and count frames
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_FB;
      frame_cnt <= 8'd0;
    end else if (frame_start) begin
      mode_q    <= mode;
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Framebuffer request: read enable follows DE, address holds during blanking
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_re   <= 1'b0;
      fb_addr <= 17'd0;
    end else begin
      fb_re <= DE;
      if (DE) begin
        fb_addr <= addr_next;
      end
    end
  end

  // Stage 0 capture plus shift delay so sideband stays aligned with returning read data
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        de_pipe[i]  <= 1'b0;
        hs_pipe[i]  <= 1'b1;
        vs_pipe[i]  <= 1'b1;
        sel_pipe[i] <= 1'b0;
        col_pipe[i] <= COL_BLACK;
      end
    end else begin
      de_pipe[0]  <= DE;
      hs_pipe[0]  <= h_sync;
      vs_pipe[0]  <= v_sync;
      sel_pipe[0] <= fb_sel;
      col_pipe[0] <= pattern_col;
      for (int i = 1; i <= RD_LAT; i++) begin
        de_pipe[i]  <= de_pipe[i-1];
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
        sel_pipe[i] <= sel_pipe[i-1];
        col_pipe[i] <= col_pipe[i-1];
      end
    end
  end

  // Output stage: blank outside the active area, otherwise framebuffer or pattern colour
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_h_sync <= 1'b1;
      vga_v_sync <= 1'b1;
      vga_r      <= 4'd0;
      vga_g      <= 4'd0;
      vga_b      <= 4'd0;
    end else begin
      vga_h_sync <= hs_pipe[RD_LAT];
      vga_v_sync <= vs_pipe[RD_LAT];
      if (!de_pipe[RD_LAT]) begin
        vga_r <= 4'd0;
        vga_g <= 4'd0;
        vga_b <= 4'd0;
      end else if (sel_pipe[RD_LAT]) begin
        vga_r <= fb_rdata[15:12];
        vga_g <= fb_rdata[10:7];
        vga_b <= fb_rdata[4:1];
      end else begin
        vga_r <= col_pipe[RD_LAT][11:8];
        vga_g <= col_pipe[RD_LAT][7:4];
        vga_b <= col_pipe[RD_LAT][3:0];
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - randomized and scan-line checks of vga_pixel_fetch at read latencies 1 and 3
module tb_vga_pixel_fetch;

  localparam int NHIST = 20000;

  logic        clk = 1'b0;
  logic        reset;
  logic        h_sync;
  logic        v_sync;
  logic        de;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic [1:0]  mode;

  logic [16:0] fb_addr_a, fb_addr_b;
  logic        fb_re_a, fb_re_b;
  logic [15:0] rdata_a;
  logic [15:0] rd_b [0:2];
  logic        hs_a, vs_a, hs_b, vs_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic [7:0]  fc_a, fc_b;

  int n_chk = 0;
  int n_fail = 0;
  int cur = 0;

  bit          h_rst [0:NHIST-1];
  logic        h_hs  [0:NHIST-1];
  logic        h_vs  [0:NHIST-1];
  logic [11:0] h_rgb [0:NHIST-1];

  int          m_mode;
  int          m_fc;
  logic [16:0] m_addr;
  logic        m_re;

  logic [11:0] bars [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

  always #20 clk = ~clk;

  vga_pixel_fetch #(.RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .DE(de),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .mode(mode),
    .fb_addr(fb_addr_a), .fb_re(fb_re_a), .fb_rdata(rdata_a),
    .vga_h_sync(hs_a), .vga_v_sync(vs_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .frame_cnt(fc_a)
  );

  vga_pixel_fetch #(.RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .DE(de),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .mode(mode),
    .fb_addr(fb_addr_b), .fb_re(fb_re_b), .fb_rdata(rd_b[2]),
    .vga_h_sync(hs_b), .vga_v_sync(vs_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_cnt(fc_b)
  );

  // Framebuffer contents are a scrambled function of the word address
  function automatic logic [15:0] mem_word(input int unsigned a);
    int unsigned v;
    v = (a * 32'd40503) ^ (a >> 5) ^ 32'h3C5A;
    return v[15:0];
  endfunction

  // Synchronous memories with one and three cycles of read latency
  always @(posedge clk) begin
    rdata_a <= mem_word(32'(fb_addr_a));
    rd_b[0] <= mem_word(32'(fb_addr_b));
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, cur, got, exp);
    end
  endtask

  // Compare one instance against the history, latency lat edges
  task automatic check_inst(input string nm, input int lat, input logic hs, input logic vs,
                            input logic [11:0] rgb, input logic [16:0] addr, input logic re,
                            input logic [7:0] fc);
    int s;
    bit flushed;
    logic e_hs, e_vs;
    logic [11:0] e_rgb;
    s = cur - lat + 1;
    flushed = 1'b0;
    for (int j = s; j <= cur; j++) begin
      if (j < 0) flushed = 1'b1;
      else if (h_rst[j]) flushed = 1'b1;
    end
    if (flushed) begin
      e_hs = 1'b1; e_vs = 1'b1; e_rgb = 12'h000;
    end else begin
      e_hs = h_hs[s]; e_vs = h_vs[s]; e_rgb = h_rgb[s];
    end
    check_eq({nm, ".hsync"}, 32'(hs), 32'(e_hs));
    check_eq({nm, ".vsync"}, 32'(vs), 32'(e_vs));
    check_eq({nm, ".rgb"}, 32'(rgb), 32'(e_rgb));
    check_eq({nm, ".fb_addr"}, 32'(addr), 32'(m_addr));
    check_eq({nm, ".fb_re"}, 32'(re), 32'(m_re));
    check_eq({nm, ".frame_cnt"}, 32'(fc), 32'(m_fc));
  endtask

  // Apply one pixel, advance the reference model, clock it and check both instances
  task automatic drive(input logic rst_i, input logic de_i, input logic hs_i, input logic vs_i,
                       input logic [9:0] x_i, input logic [9:0] y_i, input logic [1:0] m_i);
    int pm;
    int a;
    logic [15:0] w;
    logic [11:0] c;
    reset = rst_i; de = de_i; h_sync = hs_i; v_sync = vs_i;
    x_pixel = x_i; y_pixel = y_i; mode = m_i;
    h_rst[cur] = rst_i;
    h_hs[cur] = hs_i;
    h_vs[cur] = vs_i;
    h_rgb[cur] = 12'h000;
    if (rst_i) begin
      m_mode = 0; m_fc = 0; m_addr = 17'd0; m_re = 1'b0;
    end else begin
      pm = (x_i == 0 && y_i == 0) ? int'(m_i) : m_mode;
      if (x_i == 0 && y_i == 0) begin
        m_mode = int'(m_i);
        m_fc = (m_fc + 1) % 256;
      end
      a = (int'(y_i) / 2) * 320 + int'(x_i) / 2;
      m_re = de_i;
      if (de_i) m_addr = 17'(a);
      c = 12'h000;
      if (de_i) begin
        case (pm)
          0: begin
            w = mem_word(32'(a));
            c = {w[15:12], w[10:7], w[4:1]};
          end
          1: c = (x_i < 640) ? bars[int'(x_i) / 80] : 12'h000;
          2: c = (x_i[5] ^ y_i[5]) ? 12'hFFF : 12'h000;
          default: c = 12'h000;
        endcase
      end
      h_rgb[cur] = c;
    end
    @(posedge clk);
    @(negedge clk);
    check_inst("lat1", 3, hs_a, vs_a, {r_a, g_a, b_a}, fb_addr_a, fb_re_a, fc_a);
    check_inst("lat3", 5, hs_b, vs_b, {r_b, g_b, b_b}, fb_addr_b, fb_re_b, fc_b);
    cur++;
  endtask

  // One full 800-pixel line with standard 640x480 blanking and sync placement
  task automatic scan_line(input int yy, input logic [1:0] m);
    for (int xx = 0; xx < 800; xx++) begin
      drive(1'b0, (xx < 640) && (yy < 480), !((xx >= 656) && (xx < 752)),
            !((yy >= 490) && (yy < 492)), 10'(xx), 10'(yy), m);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog edge=%0d got=timeout exp=finish", cur);
    $fatal(1, "watchdog");
  end

  initial begin
    int yl [11] = '{0, 1, 7, 100, 101, 479, 490, 524, 0, 10, 32};
    logic [1:0] ml [11] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    int rst_left;
    logic [1:0] rm;
    logic [9:0] rx, ry;

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 10'd5, 10'd7, 2'b01);

    // Framebuffer fetch at x=5,y=7 after a frame start in mode 00
    drive(1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 2'b00);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 10'd5, 10'd7, 2'b00);
    check_eq("addr_962", 32'(fb_addr_a), 32'd962);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 10'd700, 10'd7, 2'b00);

    // Scan lines: mode change at y=100 must not take effect until the next y=0
    for (int i = 0; i < 11; i++) scan_line(yl[i], ml[i]);

    // Random pixels with occasional frame starts, mode flips and 3-cycle resets
    rm = 2'b00;
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 500) rst_left = 3;
      if ($urandom_range(0, 15) == 0) rm = 2'($urandom_range(0, 3));
      rx = 10'($urandom_range(0, 799));
      ry = 10'($urandom_range(0, 524));
      if ($urandom_range(0, 7) == 0) begin
        rx = 10'd0;
        ry = 10'd0;
      end
      drive(rst_left > 0, (rx < 640) && (ry < 480), 1'($urandom), 1'($urandom), rx, ry, rm);
      if (rst_left > 0) rst_left--;
    end

    // Back-to-back frame starts drive frame_cnt through 255 -> 0
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 2'b10);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 10'd700, 10'd500, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
